// File: rtl/gol_pkg.sv
// Shared definitions for the Game-of-Life key controller: key bitmap indices,
// edit opcodes and the request sequencer state encoding.
package gol_pkg;

    localparam int unsigned KEY_UP     = 0;
    localparam int unsigned KEY_DOWN   = 1;
    localparam int unsigned KEY_LEFT   = 2;
    localparam int unsigned KEY_RIGHT  = 3;
    localparam int unsigned KEY_TOGGLE = 4;
    localparam int unsigned KEY_RUN    = 5;
    localparam int unsigned KEY_STEP   = 6;
    localparam int unsigned KEY_CLEAR  = 7;
    localparam int unsigned KEY_FASTER = 8;
    localparam int unsigned KEY_SLOWER = 9;

    typedef logic [1:0] edit_op_t;

    localparam edit_op_t OP_TOGGLE = 2'b00;
    localparam edit_op_t OP_CLEAR  = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EDIT,
        S_GEN
    } state_t;

endpackage

// File: rtl/gol_key_ctrl_if.sv
// Request/acknowledge channel between the key controller (master) and the
// grid engine (slave): one edit handshake and one generation handshake.
interface gol_key_ctrl_if
    import gol_pkg::*;
#(
    parameter int unsigned GRID_W = 32,
    parameter int unsigned GRID_H = 32
);
    logic                      edit_req;
    edit_op_t                  edit_op;
    logic [$clog2(GRID_W)-1:0] edit_x;
    logic [$clog2(GRID_H)-1:0] edit_y;
    logic                      edit_ack;
    logic                      gen_req;
    logic                      gen_done;

    modport master (
        output edit_req, edit_op, edit_x, edit_y, gen_req,
        input  edit_ack, gen_done
    );

    modport slave (
        input  edit_req, edit_op, edit_x, edit_y, gen_req,
        output edit_ack, gen_done
    );
endinterface

// File: rtl/gol_key_ctrl_key_event.sv
// Registered rising-edge detector for the 16-bit key bitmap. With
// GOL_KEY_AUTOREPEAT_EN defined, held direction keys also emit repeat events.
module key_event
    import gol_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY = 12000000,
    parameter int unsigned REPEAT_RATE  = 3000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] keys,
    output logic [15:0] evt
);
    localparam int unsigned NUM_DIR = KEY_RIGHT + 1;

    logic [15:0]        keys_q;
    logic [NUM_DIR-1:0] rpt;

    if (REPEAT_DELAY == 0 || REPEAT_RATE == 0) begin : g_bad_cfg
        $error("key_event: REPEAT_DELAY and REPEAT_RATE must be nonzero");
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            keys_q <= '0;
            evt    <= '0;
        end else begin
            keys_q <= keys;
            evt    <= (keys & ~keys_q) | {{(16-NUM_DIR){1'b0}}, rpt};
        end
    end

`ifdef GOL_KEY_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RW      = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    for (genvar i = 0; i < NUM_DIR; i++) begin : g_rpt
        logic [RW-1:0] cnt;
        logic          repeating;
        logic          held;

        // The edge cycle itself is not "held"; the first repeat lands REPEAT_DELAY cycles after the edge event.
        assign held   = keys[i] & keys_q[i];
        assign rpt[i] = held && (repeating ? (cnt == RW'(REPEAT_RATE - 1))
                                           : (cnt == RW'(REPEAT_DELAY - 1)));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt       <= '0;
                repeating <= 1'b0;
            end else if (!held) begin
                cnt       <= '0;
                repeating <= 1'b0;
            end else if (rpt[i]) begin
                cnt       <= '0;
                repeating <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
`else
    assign rpt = '0;
`endif

endmodule

// File: rtl/gol_key_ctrl.sv
// Game-of-Life key command sequencer: cursor, run/pause, generation timer and
// edit/gen requests to the grid engine. Macro GOL_KEY_AUTOREPEAT_EN enables key auto-repeat.
module gol_key_ctrl
    import gol_pkg::*;
#(
    parameter int unsigned GRID_W       = 32,
    parameter int unsigned GRID_H       = 32,
    parameter int unsigned TICK_BASE    = 1000000,
    parameter int unsigned SPEED_RST    = 4,
    parameter int unsigned REPEAT_DELAY = 12000000,
    parameter int unsigned REPEAT_RATE  = 3000000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [15:0]               keys,
    output logic [$clog2(GRID_W)-1:0] cursor_x,
    output logic [$clog2(GRID_H)-1:0] cursor_y,
    gol_key_ctrl_if.master            eng,
    output logic                      running,
    output logic [2:0]                speed,
    output logic [15:0]               gen_count
);
    localparam int unsigned XW = $clog2(GRID_W);
    localparam int unsigned YW = $clog2(GRID_H);
    localparam int unsigned TW = $clog2(TICK_BASE * 8);

    logic [15:0]   evt;
    logic          unused_evt;
    state_t        state, next_state;
    logic          toggle_pend, clear_pend, gen_pend;
    logic          iss_clear, iss_toggle, iss_gen;
    logic          clr_done, gen_fin;
    logic          speed_up, speed_dn, run_on;
    logic          tick_last, tick_reload, tick_fire;
    logic [TW-1:0] tick_cnt;
    logic [31:0]   period;

    key_event #(
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) u_key_event (
        .clk (clk),
        .rst (rst),
        .keys(keys),
        .evt (evt)
    );

    assign unused_evt = ^evt[15:10];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cursor_x <= '0;
            cursor_y <= '0;
        end else begin
            if (evt[KEY_RIGHT] && !evt[KEY_LEFT])
                cursor_x <= (cursor_x == XW'(GRID_W - 1)) ? '0 : cursor_x + 1'b1;
            else if (evt[KEY_LEFT] && !evt[KEY_RIGHT])
                cursor_x <= (cursor_x == '0) ? XW'(GRID_W - 1) : cursor_x - 1'b1;
            if (evt[KEY_DOWN] && !evt[KEY_UP])
                cursor_y <= (cursor_y == YW'(GRID_H - 1)) ? '0 : cursor_y + 1'b1;
            else if (evt[KEY_UP] && !evt[KEY_DOWN])
                cursor_y <= (cursor_y == '0) ? YW'(GRID_H - 1) : cursor_y - 1'b1;
        end
    end

    assign speed_up    = evt[KEY_FASTER] && !evt[KEY_SLOWER] && (speed != 3'd7);
    assign speed_dn    = evt[KEY_SLOWER] && !evt[KEY_FASTER] && (speed != 3'd0);
    assign run_on      = evt[KEY_RUN] && !running;
    assign period      = TICK_BASE * (32'd8 - 32'(speed));
    assign tick_last   = (32'(tick_cnt) == period - 32'd1);
    assign tick_reload = speed_up || speed_dn || run_on;
    assign tick_fire   = running && !tick_reload && tick_last;

    assign clr_done = (state == S_EDIT) && eng.edit_ack && (eng.edit_op == OP_CLEAR);
    assign gen_fin  = (state == S_GEN) && eng.gen_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running  <= 1'b0;
            speed    <= 3'(SPEED_RST);
            tick_cnt <= '0;
        end else begin
            if (clr_done)
                running <= 1'b0;
            else if (evt[KEY_RUN])
                running <= !running;
            if (speed_up)
                speed <= speed + 3'd1;
            else if (speed_dn)
                speed <= speed - 3'd1;
            if (tick_reload || tick_fire)
                tick_cnt <= '0;
            else if (running)
                tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Pending flags are one deep; a tick arriving while a gen is pending or in flight is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            toggle_pend <= 1'b0;
            clear_pend  <= 1'b0;
            gen_pend    <= 1'b0;
        end else begin
            if (iss_toggle)
                toggle_pend <= 1'b0;
            else if (evt[KEY_TOGGLE])
                toggle_pend <= 1'b1;
            if (iss_clear)
                clear_pend <= 1'b0;
            else if (evt[KEY_CLEAR])
                clear_pend <= 1'b1;
            if (clr_done || iss_gen)
                gen_pend <= 1'b0;
            else if ((evt[KEY_STEP] && !running) || (tick_fire && state != S_GEN))
                gen_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        iss_clear  = 1'b0;
        iss_toggle = 1'b0;
        iss_gen    = 1'b0;
        case (state)
            S_IDLE: begin
                if (clear_pend) begin
                    iss_clear  = 1'b1;
                    next_state = S_EDIT;
                end else if (toggle_pend) begin
                    iss_toggle = 1'b1;
                    next_state = S_EDIT;
                end else if (gen_pend) begin
                    iss_gen    = 1'b1;
                    next_state = S_GEN;
                end
            end
            S_EDIT:  if (eng.edit_ack) next_state = S_IDLE;
            S_GEN:   if (eng.gen_done) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        eng.edit_req = (state == S_EDIT);
        eng.gen_req  = (state == S_GEN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eng.edit_op <= OP_TOGGLE;
            eng.edit_x  <= '0;
            eng.edit_y  <= '0;
        end else if (iss_clear || iss_toggle) begin
            eng.edit_op <= iss_clear ? OP_CLEAR : OP_TOGGLE;
            eng.edit_x  <= cursor_x;
            eng.edit_y  <= cursor_y;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            gen_count <= '0;
        else if (clr_done)
            gen_count <= '0;
        else if (gen_fin)
            gen_count <= gen_count + 16'd1;
    end

endmodule

// File: doc/gol_key_ctrl.md
Name: gol_key_ctrl

Overview:
Command sequencer between the PS/2 key decoder and the Game-of-Life grid engine. Consumes the 16-bit pressed-key bitmap and owns the cursor, run/pause state, generation timer and speed level. Issues one-at-a-time edit and generation requests to the grid engine over req/ack handshakes.

Parameters:
GRID_W, 32, grid columns; cursor_x wraps modulo GRID_W
GRID_H, 32, grid rows; cursor_y wraps modulo GRID_H
TICK_BASE, 1000000, clk cycles per speed unit; generation period = TICK_BASE*(8-speed)
SPEED_RST, 4, speed value after reset (0 slowest .. 7 fastest)
REPEAT_DELAY, 12000000, cycles a held direction key waits before auto-repeat (AUTOREPEAT_EN only)
REPEAT_RATE, 3000000, cycles between auto-repeat moves (AUTOREPEAT_EN only)

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
keys  in  16  level bitmap from the PS/2 decoder, bit high while key held; bit map in package
cursor_x  out  $clog2(GRID_W)  cursor column
cursor_y  out  $clog2(GRID_H)  cursor row
edit_req  out  1  edit request to grid engine
edit_op  out  2  00 toggle cell, 01 clear grid; stable while edit_req
edit_x  out  $clog2(GRID_W)  cell column captured at issue
edit_y  out  $clog2(GRID_H)  cell row captured at issue
edit_ack  in  1  engine accepts edit
gen_req  out  1  compute-next-generation request
gen_done  in  1  engine finished generation
running  out  1  1 = auto-run, 0 = paused
speed  out  3  current speed level
gen_count  out  16  completed generations, wraps 0xFFFF->0

Behaviour:
- Reset (async, immediate): cursor 0,0; edit_req/gen_req/running 0; edit_op/edit_x/edit_y 0; speed=SPEED_RST; gen_count 0; pending flags, tick counter, FSM cleared to S_IDLE. Reset mid-handshake drops req without clock edge.
- Key events: rising edge of each keys bit, registered; event visible 1 cycle after bit rises. Held keys produce no further events (without AUTOREPEAT_EN).
- Cursor: UP/DOWN/LEFT/RIGHT move 1 step next cycle, wrap at 0 and GRID_W-1/GRID_H-1. UP+DOWN same cycle: no y change; LEFT+RIGHT: no x change. Cursor moves in every FSM state.
- RUN toggles running; rising 0->1 reloads tick counter. STEP sets gen pending only when running=0; ignored when running.
- FASTER/SLOWER: speed +/-1, saturate at 7/0; both same cycle: no change; any change reloads tick counter.
- Tick counter: counts only while running; on reaching TICK_BASE*(8-speed)-1 sets gen pending and reloads. If gen pending or gen_req already active, the tick is dropped (no queue, overrun).
- TOGGLE and CLEAR set one-deep pending flags; repeat while pending is dropped.
- FSM S_IDLE: service priority clear > toggle > gen. Issue: assert req, edit_op/edit_x/edit_y captured (toggle uses cursor of issue cycle), go S_EDIT or S_GEN, clear that pending flag.
- S_EDIT: hold edit_req and fields until edit_ack sampled high; edit_req low next cycle, return S_IDLE. Clear ack additionally forces running=0, gen_count=0, drops gen pending.
- S_GEN: hold gen_req until gen_done sampled high; gen_req low next cycle, gen_count+1, return S_IDLE.
- ack/done while corresponding req low: ignored. At most one req high at any time.
- RUN toggled to 0 during S_GEN: outstanding gen completes and counts.

Optional Feature:
GOL_KEY_AUTOREPEAT_EN: defined -> direction key held continuously emits first move on edge, second after REPEAT_DELAY cycles, then every REPEAT_RATE cycles until release; per-key counters. Undefined -> edge-only moves; REPEAT_* parameters unused, no repeat counters synthesized.

Decomposition:
- Package gol_pkg: key bit indices (KEY_UP 0, KEY_DOWN 1, KEY_LEFT 2, KEY_RIGHT 3, KEY_TOGGLE 4, KEY_RUN 5, KEY_STEP 6, KEY_CLEAR 7, KEY_FASTER 8, KEY_SLOWER 9), edit_op encodings (OP_TOGGLE 2'b00, OP_CLEAR 2'b01), FSM state enum (S_IDLE, S_EDIT, S_GEN).
- Sub-module key_event: 16-bit edge detector, plus auto-repeat for 4 direction bits under the macro; top holds FSM, cursor, timer.

Test Plan:
- Reset, pulse keys[2] (LEFT) -> cursor_x=31, cursor_y=0; pulse UP+DOWN together -> cursor_y stays 0.
- RIGHT x3 from 0,0, pulse TOGGLE, edit_ack low 5 cycles -> edit_req=1, edit_op=00, edit_x=3 held 5 cycles; ack=1 -> edit_req=0 next cycle.
- TICK_BASE=4, speed=4, pulse RUN, gen_done returned 1 cycle after gen_req -> gen_req every 16 cycles, gen_count 1,2,3.
- Running, gen_done withheld 40 cycles -> single gen_req held throughout, gen_count +1 only once after done.
- Running with gen_count=5, pulse STEP then CLEAR, ack -> STEP ignored, edit_op=01, then running=0, gen_count=0.
- Assert rst mid edit_req between clock edges -> edit_req=0 immediately, speed=4, cursor 0,0.
